// File: rtl/sub_div_seq_if.sv
// Start/done handshake bundle between the execute stage and the sequential divider.
interface sub_div_seq_if;
   logic        start;
   logic        is_signed;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_zero;

   modport master (
      output start, is_signed, dividend, divisor,
      input  busy, done, quotient, remainder, div_zero
   );

   modport slave (
      input  start, is_signed, dividend, divisor,
      output busy, done, quotient, remainder, div_zero
   );
endinterface

// File: rtl/sub_div_seq.sv
// Sequential 32-bit signed/unsigned restoring divider. One shared subtractor does the
// operand negation, all 32 division steps and the final sign fix-up.

module fast_sub_32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] diff,
   output logic        no_borrow
);
   logic [32:0] sum;

   // a + ~b + 1; carry out set means a >= b unsigned
   assign sum       = {1'b0, a} + {1'b0, ~b} + 33'd1;
   assign diff      = sum[31:0];
   assign no_borrow = sum[32];
endmodule

module sub_div_seq (
   input  logic           clk,
   input  logic           rst,
   sub_div_seq_if.slave   bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_NEG_A, S_NEG_B, S_ITER, S_FIX_Q, S_FIX_R, S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] q_q, q_d;
   logic [31:0] d_q, d_d;
   logic [31:0] r_q, r_d;
   logic        sgn_q, sgn_d;
   logic        sa_q, sa_d;
   logic        sb_q, sb_d;
   logic        dz_q, dz_d;
   logic [31:0] quot_q, quot_d;
   logic [31:0] rem_q, rem_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic [31:0] sub_a, sub_b, sub_diff;
   logic        sub_nb;
   logic [32:0] rp;
   logic        take;

   fast_sub_32 u_sub (
      .a         (sub_a),
      .b         (sub_b),
      .diff      (sub_diff),
      .no_borrow (sub_nb)
   );

   // Shifted partial remainder; q_q doubles as the dividend shift register.
   assign rp = {r_q, q_q[31]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      d_d     = d_q;
      r_d     = r_q;
      sgn_d   = sgn_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      dz_d    = dz_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      sub_a   = 32'd0;
      sub_b   = 32'd0;
      take    = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (bus.start) begin
               q_d     = bus.dividend;
               d_d     = bus.divisor;
               sgn_d   = bus.is_signed;
               r_d     = 32'd0;
               cnt_d   = 6'd0;
               state_d = S_NEG_A;
            end
         end
         S_NEG_A: begin
            sub_b = q_q;
            sa_d  = sgn_q & q_q[31];
            if (sgn_q & q_q[31]) q_d = sub_diff;
            state_d = S_NEG_B;
         end
         S_NEG_B: begin
            sub_b = d_q;
            sb_d  = sgn_q & d_q[31];
            if (sgn_q & d_q[31]) d_d = sub_diff;
            dz_d    = (d_q == 32'd0);
            state_d = S_ITER;
         end
         S_ITER: begin
            sub_a = rp[31:0];
            sub_b = d_q;
            // A set bit 32 means r' already exceeds any 32-bit divisor.
            take  = rp[32] | sub_nb;
            r_d   = take ? sub_diff : rp[31:0];
            q_d   = {q_q[30:0], take};
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) state_d = S_FIX_Q;
         end
         S_FIX_Q: begin
            sub_b   = q_q;
            quot_d  = (sgn_q & (sa_q ^ sb_q) & ~dz_q) ? sub_diff : q_q;
            state_d = S_FIX_R;
         end
         S_FIX_R: begin
            sub_b   = r_q;
            rem_d   = (sgn_q & sa_q) ? sub_diff : r_q;
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 6'd0;
         q_q     <= 32'd0;
         d_q     <= 32'd0;
         r_q     <= 32'd0;
         sgn_q   <= 1'b0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         dz_q    <= 1'b0;
         quot_q  <= 32'd0;
         rem_q   <= 32'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         d_q     <= d_d;
         r_q     <= r_d;
         sgn_q   <= sgn_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         dz_q    <= dz_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.quotient  = quot_q;
   assign bus.remainder = rem_q;
   assign bus.div_zero  = dz_q;
endmodule

// File: tb/tb_sub_div_seq.sv
// Directed table-driven bench for sub_div_seq plus handshake/reset corner sequences.
module tb_sub_div_seq;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   sub_div_seq_if bus ();

   sub_div_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive start before an edge; returns #1 after the accepting edge.
   task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      bus.start     = 1'b1;
      bus.is_signed = sgn;
      bus.dividend  = a;
      bus.divisor   = b;
      @(posedge clk); #1;
      bus.start     = 1'b0;
   endtask

   // lat = edge index (accepting edge = 0) at which done is first sampled high.
   task automatic wait_done(output int lat, output int bcnt);
      lat  = 1;
      bcnt = 0;
      while (!bus.done && lat < 80) begin
         if (bus.busy) bcnt++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   initial begin
      int lat, bc, dcnt;
      vecs[0] = '{1'b0, 32'd100,       32'd7,        32'd14,       32'd2,        1'b0};
      vecs[1] = '{1'b1, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
      vecs[2] = '{1'b0, 32'hFFFFFFF9,  32'd2,        32'h7FFFFFFC, 32'd1,        1'b0};
      vecs[3] = '{1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0};
      vecs[4] = '{1'b1, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0};
      vecs[5] = '{1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0};
      vecs[6] = '{1'b0, 32'hFFFFFFFF,  32'd1,        32'hFFFFFFFF, 32'd0,        1'b0};
      vecs[7] = '{1'b1, 32'hFFFFFFFB,  32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1};
      vecs[8] = '{1'b0, 32'd5,         32'd0,        32'hFFFFFFFF, 32'd5,        1'b1};

      rst = 1'b1;
      bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_quot", bus.quotient, 32'd0);
      chk("rst_rem", bus.remainder, 32'd0);
      chk("rst_dz", {31'd0, bus.div_zero}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) begin
         issue(vecs[i].sgn, vecs[i].a, vecs[i].b);
         wait_done(lat, bc);
         chk($sformatf("v%0d_lat", i), lat, 32'd37);
         chk($sformatf("v%0d_busycnt", i), bc, 32'd36);
         chk($sformatf("v%0d_done_busy", i), {31'd0, bus.busy}, 32'd0);
         chk($sformatf("v%0d_quot", i), bus.quotient, vecs[i].q);
         chk($sformatf("v%0d_rem", i), bus.remainder, vecs[i].r);
         chk($sformatf("v%0d_dz", i), {31'd0, bus.div_zero}, {31'd0, vecs[i].dz});
         @(posedge clk); #1;
         chk($sformatf("v%0d_done_pulse", i), {31'd0, bus.done}, 32'd0);
         chk($sformatf("v%0d_quot_hold", i), bus.quotient, vecs[i].q);
      end

      // Reset during ITER step 10 aborts without a done pulse.
      issue(1'b0, 32'd100, 32'd7);
      repeat (12) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_busy", {31'd0, bus.busy}, 32'd0);
      chk("abort_quot", bus.quotient, 32'd0);
      chk("abort_rem", bus.remainder, 32'd0);
      chk("abort_dz", {31'd0, bus.div_zero}, 32'd0);
      dcnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done || bus.busy) dcnt++;
         @(posedge clk); #1;
      end
      chk("abort_quiet", dcnt, 32'd0);
      issue(1'b0, 32'd1, 32'd1);
      wait_done(lat, bc);
      chk("post_rst_lat", lat, 32'd37);
      chk("post_rst_quot", bus.quotient, 32'd1);
      chk("post_rst_rem", bus.remainder, 32'd0);
      @(posedge clk); #1;

      // rst and start in the same cycle: rst wins.
      rst = 1'b1;
      issue(1'b0, 32'd50, 32'd5);
      rst = 1'b0;
      chk("rst_start_busy", {31'd0, bus.busy}, 32'd0);
      @(posedge clk); #1;
      chk("rst_start_busy2", {31'd0, bus.busy}, 32'd0);

      // start while busy is ignored.
      issue(1'b0, 32'd100, 32'd7);
      repeat (9) @(posedge clk);
      #1;
      issue(1'b1, 32'd9, 32'd3);
      wait_done(lat, bc);
      chk("ign_lat", lat, 32'd27);
      chk("ign_quot", bus.quotient, 32'd14);
      chk("ign_rem", bus.remainder, 32'd2);

      // start in the done cycle: back-to-back.
      issue(1'b0, 32'd9, 32'd3);
      chk("b2b_busy", {31'd0, bus.busy}, 32'd1);
      chk("b2b_done", {31'd0, bus.done}, 32'd0);
      chk("b2b_quot_hold", bus.quotient, 32'd14);
      wait_done(lat, bc);
      chk("b2b_lat", lat, 32'd37);
      chk("b2b_quot", bus.quotient, 32'd3);
      chk("b2b_rem", bus.remainder, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sub_div_seq.md
# sub_div_seq

Multi-cycle 32-bit integer divider sequencer that time-shares a single `fast_sub_32` subtractor instance for operand negation, 32 restoring-division steps and result sign fix-up. Serves the RV32 execute stage's DIV/DIVU/REM/REMU path with a start/done handshake. Every arithmetic subtraction inside the block goes through that one subtractor; no second 32-bit subtractor or adder is permitted.

## Interface
Parameters: none (width fixed at 32).

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE or DONE
- `is_signed`  in  1  1 = DIV/REM semantics, 0 = DIVU/REMU; captured with `start`
- `dividend`  in  32  captured with `start`
- `divisor`  in  32  captured with `start`
- `busy`  out  1  high from NEG_A through FIX_R
- `done`  out  1  one-cycle pulse; results valid
- `quotient`  out  32  registered; held until next accepted `start`
- `remainder`  out  32  registered; held until next accepted `start`
- `div_zero`  out  1  registered flag: captured divisor was 0; valid with `done`

## Operation
- States: IDLE, NEG_A, NEG_B, ITER, FIX_Q, FIX_R, DONE. Path is fixed; no state is skipped.
- IDLE/DONE + `start`: latch operands and `is_signed`, clear the 6-bit step counter, go to NEG_A. DONE without `start` goes to IDLE.
- NEG_A: subtractor computes 0 - dividend. Store |dividend| if signed and dividend[31]=1, else store dividend unchanged. Record `sa`.
- NEG_B: same operation for divisor. Record `sb`. Set `div_zero` = (divisor == 0).
- ITER, 32 cycles, counter 0..31:
  - Form the 33-bit shifted remainder r' = {R, Q[31]}.
  - Subtractor computes r'[31:0] - D.
  - If r'[32]=1 or r'[31:0] >= D (unsigned): R <= difference, shift in quotient bit 1.
  - Otherwise: R <= r'[31:0], shift in quotient bit 0.
  - Q shifts left each step.
- FIX_Q: if signed, (sa^sb)=1 and !div_zero, quotient <= 0 - Q via the subtractor. Otherwise quotient <= Q.
- FIX_R: if signed and sa=1, remainder <= 0 - R via the subtractor. Otherwise remainder <= R.
- Divide by zero: the restoring loop naturally yields Q=0xFFFFFFFF and R=|dividend|.
  - FIX_Q skips negation when `div_zero` is set, so quotient = 0xFFFFFFFF.
  - FIX_R restores the sign, so remainder = original dividend.
- Signed overflow (0x80000000 / 0xFFFFFFFF): no special case. It yields quotient 0x80000000, remainder 0.
- Subtractor operand muxes are driven by state. The subtractor's A input is 0 in NEG_A, NEG_B, FIX_Q and FIX_R.

## Timing
- Reset: state IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_zero`=0, counter 0.
- `start` accepted at edge k:
  - `busy`=1 for cycles k+1..k+36 (NEG_A, NEG_B, 32×ITER, FIX_Q, FIX_R).
  - `done`=1 for cycle k+37 only, with `busy`=0.
- Fixed latency of 37 cycles for every operand value, including divide by zero and overflow.
- `start` during `busy` is ignored: no capture, no effect on the operation in flight.
- `start` during the DONE cycle is accepted. This gives back-to-back operations: `busy` rises the next cycle and the outputs update only at the new FIX_Q/FIX_R.
- `rst` mid-operation takes effect at the next edge: IDLE, all outputs at reset values, no `done`. The aborted operation leaves no trace.
- `rst` and `start` in the same cycle: `rst` wins.

## Test plan
- Unsigned 100 / 7 (`is_signed`=0), start at edge 0 -> `done` only at edge 37, quotient=14, remainder=2, div_zero=0, `busy` high for exactly 36 cycles.
- Signed 0xFFFFFFF9 / 2 (-7/2) -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Same operands unsigned -> quotient=0x7FFFFFFC, remainder=1.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_zero=0.
- Divide by zero: signed 0xFFFFFFFB / 0 -> quotient=0xFFFFFFFF, remainder=0xFFFFFFFB, div_zero=1. Unsigned 5/0 -> quotient=0xFFFFFFFF, remainder=5.
- Assert `start` with new operands at cycle 10 of `busy` -> ignored, first result unchanged. Assert `start` in the `done` cycle with 9/3 -> second `done` 37 cycles later, quotient=3, remainder=0.
- Assert `rst` during ITER step 10 -> next cycle `busy`=0, outputs zero, no `done` pulse. Then a 1/1 request -> quotient=1, remainder=0 at the expected 37-cycle latency.
